// File: rtl/ricker_window_sched.sv
// Ricker window scheduler: raster pixels -> 3x3 window -> kernel -> registered result stream.
// Latency: 2 cycles from pixel accept to out_valid; throughput 1 pixel/cycle.
// Backpressure: out_ready low holds the result; in_ready drops once a pending window cannot drain.
// Optional stall counter output enabled by macro RICKER_STALL_CNT_EN.
module ricker_window_sched #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [71:0] win,
    input  logic [7:0]  kern_out,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        out_last
`ifdef RICKER_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           done_nxt;
    logic           start_acc;

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;

    // Line buffers: lb0 holds the row two above the current one, lb1 the row just above.
    logic [7:0]     lb0 [IMG_W];
    logic [7:0]     lb1 [IMG_W];

    logic [71:0]    win_q;
    logic           win_vld;
    logic           win_last;

    logic           accept;
    logic           out_free;
    logic           load;
    logic           out_hs;
    logic           qual;
    logic           at_fill_end;
    logic           at_last;
    logic           in_phase;

    assign busy        = (state != S_IDLE);
    assign in_phase    = (state == S_FILL) || (state == S_RUN);
    assign out_free    = !out_valid || out_ready;
    assign in_ready    = in_phase && (!win_vld || out_free);
    assign accept      = in_valid && in_ready;
    assign load        = win_vld && out_free;
    assign out_hs      = out_valid && out_ready;
    assign qual        = (row >= ROW_TWO) && (col >= COL_TWO);
    assign at_fill_end = (row == ROW_TWO) && (col == COL_ONE);
    assign at_last     = (row == ROW_LAST) && (col == COL_LAST);
    assign start_acc   = (state == S_IDLE) && start;
    assign win         = win_q;

    // State register and registered done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state: fill two rows plus two pixels, stream the rest, then wait for the last result to leave
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (accept && at_fill_end) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && at_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_hs && out_last) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Raster position of the next pixel to be accepted; restarts with each frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (start_acc) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Rotate the current column through the two line buffers (contents need no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= lb1[col];
            lb1[col] <= in_data;
        end
    end

    // Window shifts left by one column; new right column is {row-2, row-1, current pixel}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (accept) begin
            win_q <= {in_data,  win_q[71:64], win_q[63:56],
                      lb1[col], win_q[47:40], win_q[39:32],
                      lb0[col], win_q[23:16], win_q[15:8]};
        end
    end

    // A window is only usable when all three columns come from the same row span
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_vld  <= 1'b0;
            win_last <= 1'b0;
        end else if (accept) begin
            win_vld  <= qual;
            win_last <= qual && at_last;
        end else if (load) begin
            win_vld  <= 1'b0;
            win_last <= 1'b0;
        end
    end

    // Output register: a new result overrides a concurrent handshake so valid stays high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= kern_out;
            out_last  <= win_last;
        end else if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef RICKER_STALL_CNT_EN
    // Saturating count of cycles the downstream held off a pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (busy && out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ricker_window_sched.sv
module tb_ricker_window_sched;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        start_v;
    logic [2:0]        busy_v;
    logic [2:0]        done_v;
    logic [2:0]        in_valid_v;
    logic [2:0][7:0]   in_data_v;
    logic [2:0]        in_ready_v;
    logic [2:0][71:0]  win_v;
    logic [2:0][7:0]   kern_v;
    logic [2:0]        out_valid_v;
    logic [2:0][7:0]   out_data_v;
    logic [2:0]        out_ready_v;
    logic [2:0]        out_last_v;
`ifdef RICKER_STALL_CNT_EN
    logic [2:0][31:0]  stall_v;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] frame [64];

    always #5 clk = ~clk;

    // Reference kernel: |centre - mean of the 8 neighbours|
    function automatic logic [7:0] kern(input logic [71:0] w);
        int s;
        int d;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            if (k != 4) s += int'(w[k*8 +: 8]);
        end
        d = int'(w[39:32]) - (s / 8);
        return (d < 0) ? 8'(-d) : 8'(d);
    endfunction

    assign kern_v[0] = kern(win_v[0]);
    assign kern_v[1] = kern(win_v[1]);
    assign kern_v[2] = kern(win_v[2]);

    // idx 0: 4x4, idx 1: 3x3, idx 2: 8x8
    ricker_window_sched #(.IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .in_valid(in_valid_v[0]), .in_data(in_data_v[0]), .in_ready(in_ready_v[0]),
        .win(win_v[0]), .kern_out(kern_v[0]), .out_valid(out_valid_v[0]),
        .out_data(out_data_v[0]), .out_ready(out_ready_v[0]), .out_last(out_last_v[0])
`ifdef RICKER_STALL_CNT_EN
        , .stall_cnt(stall_v[0])
`endif
    );

    ricker_window_sched #(.IMG_W(3), .IMG_H(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .in_valid(in_valid_v[1]), .in_data(in_data_v[1]), .in_ready(in_ready_v[1]),
        .win(win_v[1]), .kern_out(kern_v[1]), .out_valid(out_valid_v[1]),
        .out_data(out_data_v[1]), .out_ready(out_ready_v[1]), .out_last(out_last_v[1])
`ifdef RICKER_STALL_CNT_EN
        , .stall_cnt(stall_v[1])
`endif
    );

    ricker_window_sched #(.IMG_W(8), .IMG_H(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .in_valid(in_valid_v[2]), .in_data(in_data_v[2]), .in_ready(in_ready_v[2]),
        .win(win_v[2]), .kern_out(kern_v[2]), .out_valid(out_valid_v[2]),
        .out_data(out_data_v[2]), .out_ready(out_ready_v[2]), .out_last(out_last_v[2])
`ifdef RICKER_STALL_CNT_EN
        , .stall_cnt(stall_v[2])
`endif
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame from 'frame' into DUT idx, checking every result against a golden window model.
    task automatic run_frame(input int idx, input int w, input int h, input bit rnd_rdy,
                             input int mid_start, input int abort_at,
                             output int acc_last_cyc, output int first_ov_cyc,
                             output logic [71:0] first_win, output logic [7:0] last_res);
        logic [7:0]  gold [64];
        logic [71:0] wv;
        int          nres, npix, pix, got, cyc, stall_exp;
        bit          finished, aborted, prev_stall, last_hs_prev, rdy;
        logic [7:0]  prev_dat;
        nres = 0; npix = w * h; pix = 0; got = 0; cyc = 0; stall_exp = 0;
        finished = 0; aborted = 0; prev_stall = 0; last_hs_prev = 0; prev_dat = '0;
        acc_last_cyc = -1; first_ov_cyc = -1; first_win = '0; last_res = '0;
        for (int i = 0; i < 64; i++) gold[i] = '0;
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        wv[(3*rr+cc)*8 +: 8] = frame[(r-2+rr)*w + (c-2+cc)];
                gold[nres] = kern(wv);
                nres++;
            end
        end
        @(negedge clk); start_v[idx] = 1'b1;
        @(negedge clk); start_v[idx] = 1'b0;
        chk("busy_after_start", 72'(busy_v[idx]), 72'(1));
        while (!finished && cyc < 4000) begin
            if (done_v[idx]) begin
                chk("done_after_last_hs", 72'(last_hs_prev), 72'(1));
                finished = 1;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 72'(out_valid_v[idx]), 72'(1));
                    chk("hold_data", 72'(out_data_v[idx]), 72'(prev_dat));
                end
                rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                out_ready_v[idx] = rdy;
                in_valid_v[idx]  = (pix < npix);
                in_data_v[idx]   = (pix < npix) ? frame[pix] : 8'h00;
                start_v[idx]     = (pix == mid_start);
                #1;
                if (in_valid_v[idx] && in_ready_v[idx]) begin
                    if (pix == npix - 1) acc_last_cyc = cyc;
                    pix++;
                end
                if (out_valid_v[idx] && first_ov_cyc < 0) begin
                    first_ov_cyc = cyc;
                    first_win    = win_v[idx];
                end
                last_hs_prev = 0;
                if (out_valid_v[idx] && rdy) begin
                    chk("result", 72'(out_data_v[idx]), 72'(gold[got]));
                    chk("out_last", 72'(out_last_v[idx]), 72'(got == nres - 1));
                    last_res = out_data_v[idx];
                    got++;
                    last_hs_prev = (got == nres);
                end
                prev_stall = out_valid_v[idx] && !rdy;
                prev_dat   = out_data_v[idx];
                if (busy_v[idx] && prev_stall) stall_exp++;
                if (abort_at >= 0 && pix == abort_at) begin
                    aborted  = 1;
                    finished = 1;
                end else begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        if (!aborted) begin
            start_v[idx] = 1'b0;
            in_valid_v[idx] = 1'b0;
            out_ready_v[idx] = 1'b1;
            chk("frame_finished", 72'(finished), 72'(1));
            chk("result_count", 72'(got), 72'(nres));
            chk("pixel_count", 72'(pix), 72'(npix));
            chk("busy_after_done", 72'(busy_v[idx]), 72'(0));
`ifdef RICKER_STALL_CNT_EN
            chk("stall_cnt", 72'(stall_v[idx]), 72'(stall_exp));
`endif
            repeat (3) begin
                @(negedge clk);
                chk("no_extra_valid", 72'(out_valid_v[idx]), 72'(0));
                chk("done_single", 72'(done_v[idx]), 72'(0));
            end
        end
    endtask

    int          acc_c, ov_c;
    logic [71:0] fw;
    logic [7:0]  lr;

    initial begin
        rst_n = 1'b0;
        start_v = '0; in_valid_v = '0; in_data_v = '0; out_ready_v = '1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 72'(in_ready_v[2]), 72'(0));
        chk("rst_busy", 72'(busy_v[2]), 72'(0));
        chk("rst_done", 72'(done_v[2]), 72'(0));
        chk("rst_out_valid", 72'(out_valid_v[0]), 72'(0));
        chk("rst_win", win_v[1], 72'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 4x4 flat frame: four zero results, last flagged
        for (int i = 0; i < 16; i++) frame[i] = 8'd100;
        run_frame(0, 4, 4, 1'b0, -1, -1, acc_c, ov_c, fw, lr);
        chk("flat_result", 72'(lr), 72'(0));

        // 3x3 isolated centre
        for (int i = 0; i < 9; i++) frame[i] = (i == 4) ? 8'd80 : 8'd0;
        run_frame(1, 3, 3, 1'b0, -1, -1, acc_c, ov_c, fw, lr);
        chk("centre_peak", 72'(lr), 72'(80));

        // 3x3 inverted: negative difference folds to magnitude
        for (int i = 0; i < 9; i++) frame[i] = (i == 4) ? 8'd0 : 8'd80;
        run_frame(1, 3, 3, 1'b0, -1, -1, acc_c, ov_c, fw, lr);
        chk("centre_pit", 72'(lr), 72'(80));

        // 3x3 ramp: window byte order and accept-to-valid latency
        for (int i = 0; i < 9; i++) frame[i] = 8'(i);
        run_frame(1, 3, 3, 1'b0, -1, -1, acc_c, ov_c, fw, lr);
        chk("latency", 72'(ov_c - acc_c), 72'(2));
        chk("win_b0", 72'(fw[7:0]), 72'(0));
        chk("win_b4", 72'(fw[39:32]), 72'(4));
        chk("win_b8", 72'(fw[71:64]), 72'(8));
        chk("ramp_result", 72'(lr), 72'(0));

        // 8x8 random frame with random downstream stalls
        for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
        run_frame(2, 8, 8, 1'b1, -1, -1, acc_c, ov_c, fw, lr);

        // Abort after 20 pixels with an asynchronous reset
        for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
        run_frame(2, 8, 8, 1'b0, -1, 20, acc_c, ov_c, fw, lr);
        @(posedge clk); #1;
        in_valid_v[2] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 72'(in_ready_v[2]), 72'(0));
        chk("abort_busy", 72'(busy_v[2]), 72'(0));
        chk("abort_done", 72'(done_v[2]), 72'(0));
        chk("abort_out_valid", 72'(out_valid_v[2]), 72'(0));
        chk("abort_out_data", 72'(out_data_v[2]), 72'(0));
        chk("abort_out_last", 72'(out_last_v[2]), 72'(0));
        chk("abort_win", win_v[2], 72'(0));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_done", 72'(done_v[2]), 72'(0));
        run_frame(2, 8, 8, 1'b0, -1, -1, acc_c, ov_c, fw, lr);

        // in_valid high while idle, then start re-pulsed mid-frame
        in_valid_v[2] = 1'b1;
        in_data_v[2]  = 8'hAA;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("idle_in_ready", 72'(in_ready_v[2]), 72'(0));
        end
        for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
        run_frame(2, 8, 8, 1'b1, 17, -1, acc_c, ov_c, fw, lr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ricker_window_sched.md
Name: ricker_window_sched

Overview:
- Streams a raster-order 8-bit greyscale frame and builds a 3x3 sliding window with two line buffers.
- Drives the 72-bit window bus of an external combinational ricker_wavelet kernel and registers its 8-bit result onto a valid/ready output stream.
- Sequences one frame per start pulse. Emits only interior pixels, (IMG_W-2)x(IMG_H-2) results per frame.

Parameters:
- IMG_W, 8, frame width in pixels; must be >= 3.
- IMG_H, 8, frame height in pixels; must be >= 3.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse that begins a frame; ignored unless IDLE.
- busy  out  1  high in FILL/RUN/DRAIN.
- done  out  1  1-cycle pulse after the last output handshake.
- in_valid  in  1  pixel valid.
- in_data  in  8  pixel, raster order.
- in_ready  out  1  pixel accept.
- win  out  72  to kernel; byte k = row r, col c, k=3r+c; r=0 oldest row, c=0 oldest column; byte 4 = centre.
- kern_out  in  8  kernel result for current win.
- out_valid  out  1  result valid.
- out_data  out  8  registered kernel result.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with final result of frame.

Behaviour:
- Reset values: in_ready=0, busy=0, done=0, out_valid=0, out_data=0, out_last=0, win=0. Reset also clears counters, state, window regs and the win_vld flag. Line-buffer contents are don't-care.
- States: IDLE -> (start) FILL -> RUN -> DRAIN -> IDLE.
- FILL: pixels are accepted until row 2 col 1 has been taken (2*IMG_W+2 pixels), then RUN.
- RUN: continues until pixel W*H-1 is accepted, then DRAIN.
- DRAIN: waits for the final out handshake, pulses done, returns to IDLE.
- Handshake: pixel accepted when in_valid&&in_ready.
- in_ready = (FILL||RUN) && (!win_vld || out_free), where out_free = !out_valid||out_ready.
- On accept: the pixel shifts into the window column regs and line buffers; col and row counters advance, col wraps at IMG_W-1.
- win_vld is set the next cycle iff accepted row>=2 && col>=2.
- Pipeline: accept at edge t -> win updated at t+1. At edge t+1, if win_vld && out_free: out_data<=kern_out, out_valid<=1, win_vld cleared unless a new qualifying pixel is accepted.
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput: 1 pixel/cycle.
- out_valid holds with stable out_data until out_ready. Clears on handshake unless a new result is loaded the same cycle.
- Row wrap: window column regs stay valid across the row boundary, but results are suppressed for col<2. No result is ever built from pixels of two different rows.
- out_last = out_valid for result (row H-1, col W-1).
- Simultaneous out handshake and new result load: the new result wins and out_valid stays 1.
- start while busy: ignored, no effect on the frame in progress.
- in_valid while IDLE: not accepted (in_ready=0).
- Reset mid-frame: the frame is discarded with no done pulse. The next start begins a fresh frame.

Optional Feature:
- Macro RICKER_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0]. It counts cycles with busy && out_valid && !out_ready, clears on accepted start and on reset, and saturates at 0xFFFFFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- 4x4 frame, all pixels 100, out_ready=1 -> 4 results of 0; out_last on the 4th; done pulses the cycle after.
- 3x3 frame, centre 80, others 0 -> single result 80 with out_last=1. Second run with centre 0, others 80 -> result 80 (sub = -80, magnitude taken).
- 3x3 ramp 0..8 -> at the result cycle win[7:0]=0, win[39:32]=4, win[71:64]=8. First out_valid exactly 2 cycles after the accept of pixel 8.
- 8x8 random frame, out_ready toggled pseudo-randomly at 50% -> 36 results match a golden model in order. No result lost or duplicated; out_data stable while stalled. With RICKER_STALL_CNT_EN defined, stall_cnt equals the counted stall cycles.
- Assert rst_n low after 20 pixels of an 8x8 frame -> all outputs at reset values. A new start processes a full frame correctly with no done from the aborted frame.
- start pulsed mid-frame and in_valid held high in IDLE -> frame unaffected and exactly 36 outputs; no pixel accepted while IDLE.
